// File: rtl/rv32imf_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rv32imf_pkg
//  Description : Shared types and helpers for the RV32IMF instruction fetch path.
//  Revision    : 1.0 - initial release
// ============================================================================
package rv32imf_pkg;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } fetch_entry_t;

    localparam logic [31:0] c_INSTR_BYTES = 32'd4;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/rv32imf_fetch_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : rv32imf_fetch_fifo
//  Description : Registered response FIFO with flush; head visible the cycle
//                after a push.
//  Revision    : 1.0 - initial release
// ============================================================================
module rv32imf_fetch_fifo
    import rv32imf_pkg::*;
#(
    parameter int  DEPTH = 2,
    parameter type T     = fetch_entry_t
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  T                           push_data,
    input  logic                       pop,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       valid,
    output T                           head
);

    localparam int c_PW = $clog2(DEPTH);
    localparam int c_CW = $clog2(DEPTH + 1);

    T                r_mem [DEPTH];
    logic [c_PW-1:0] r_wptr;
    logic [c_PW-1:0] r_rptr;
    logic [c_CW-1:0] r_count;

    function automatic logic [c_PW-1:0] ptr_inc(input logic [c_PW-1:0] p);
        return (p == c_PW'(DEPTH - 1)) ? '0 : p + c_PW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            r_mem[r_wptr] <= push_data;
        end
    end

    // Flush wins over push: a response landing on a redirect belongs to the old stream.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (push) begin
                r_wptr <= ptr_inc(r_wptr);
            end
            if (pop) begin
                r_rptr <= ptr_inc(r_rptr);
            end
            if (push && !pop) begin
                r_count <= r_count + c_CW'(1);
            end else if (pop && !push) begin
                r_count <= r_count - c_CW'(1);
            end
        end
    end

    assign count = r_count;
    assign valid = (r_count != '0);
    assign head  = r_mem[r_rptr];

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst && !flush) begin
            assert (!(push && !pop && r_count == c_CW'(DEPTH)));
            assert (!(pop && r_count == '0));
        end
    end
`endif

endmodule
`default_nettype wire

// File: rtl/rv32imf_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : rv32imf_fetch_ctrl
//  Description : OBI instruction fetch controller with credit-based request
//                issue, redirect handling and stale-response discard.
//  Revision    : 1.0 - initial release
// ============================================================================
module rv32imf_fetch_ctrl
    import rv32imf_pkg::*;
#(
    parameter int DEPTH           = 2,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic        branch_i,
    input  logic [31:0] branch_addr_i,
    input  logic        fetch_ready_i,
    output logic        fetch_valid_o,
    output logic [31:0] fetch_rdata_o,
    output logic        fetch_err_o,
    output logic        instr_req_o,
    output logic [31:0] instr_addr_o,
    input  logic        instr_gnt_i,
    input  logic        instr_rvalid_i,
    input  logic [31:0] instr_rdata_i,
    input  logic        instr_err_i,
    output logic        busy_o
);

    localparam int c_OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int c_CW = $clog2(DEPTH + 1);

    logic [31:0]     r_addr;
    logic [31:0]     r_target;
    logic [c_OW-1:0] r_outstanding;
    logic [c_OW-1:0] r_discard;
    logic            r_drop_pending;
    logic            r_held;
    logic            r_booted;

    logic [c_CW-1:0] w_count;
    logic            w_fifo_valid;
    fetch_entry_t    w_head;
    fetch_entry_t    w_push_entry;
    logic            w_credit;
    logic            w_gnt_fire;
    logic            w_drop;
    logic            w_push;
    logic            w_pop;
    logic [c_OW-1:0] w_out_next;
    logic [31:0]     w_branch_target;
    logic            w_unused_addr_bits;

    assign w_unused_addr_bits = ^branch_addr_i[1:0];
    assign w_branch_target    = word_align(branch_addr_i);

    // Credit reserves a FIFO slot for every response that may still arrive.
    always_comb begin
        w_credit = req_i && r_booted
                   && (32'(r_outstanding) < 32'(MAX_OUTSTANDING))
                   && ((32'(r_outstanding) + 32'(w_count)) < 32'(DEPTH));
        instr_req_o  = r_held || w_credit;
        instr_addr_o = r_addr;
        w_gnt_fire   = instr_req_o && instr_gnt_i;
        w_drop       = instr_rvalid_i && (r_discard != '0);
        w_push       = instr_rvalid_i && (r_discard == '0);
        w_pop        = w_fifo_valid && fetch_ready_i && !branch_i;
        w_out_next   = r_outstanding + c_OW'(w_gnt_fire) - c_OW'(instr_rvalid_i);
        w_push_entry = '{rdata: instr_rdata_i, err: instr_err_i};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr         <= '0;
            r_target       <= '0;
            r_outstanding  <= '0;
            r_discard      <= '0;
            r_drop_pending <= 1'b0;
            r_held         <= 1'b0;
            r_booted       <= 1'b0;
        end else begin
            r_held        <= instr_req_o && !instr_gnt_i;
            r_outstanding <= w_out_next;
            if (branch_i) begin
                r_booted  <= 1'b1;
                r_discard <= w_out_next;
                // An ungranted request must keep its address; redirect is deferred.
                if (instr_req_o && !instr_gnt_i) begin
                    r_drop_pending <= 1'b1;
                    r_target       <= w_branch_target;
                end else begin
                    r_drop_pending <= 1'b0;
                    r_addr         <= w_branch_target;
                end
            end else begin
                r_discard <= r_discard - c_OW'(w_drop)
                             + c_OW'(w_gnt_fire && r_drop_pending);
                if (w_gnt_fire) begin
                    r_addr         <= r_drop_pending ? r_target : r_addr + c_INSTR_BYTES;
                    r_drop_pending <= 1'b0;
                end
            end
        end
    end

    rv32imf_fetch_fifo #(
        .DEPTH (DEPTH),
        .T     (fetch_entry_t)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data (w_push_entry),
        .pop       (w_pop),
        .flush     (branch_i),
        .count     (w_count),
        .valid     (w_fifo_valid),
        .head      (w_head)
    );

    assign fetch_valid_o = w_fifo_valid;
    assign fetch_rdata_o = w_fifo_valid ? w_head.rdata : '0;
    assign fetch_err_o   = w_fifo_valid && w_head.err;
    assign busy_o        = (r_outstanding != '0) || instr_req_o;

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(instr_rvalid_i && r_outstanding == '0));
            assert (r_discard <= r_outstanding);
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_rv32imf_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rv32imf_fetch_ctrl
//  Description : Self-checking bench; transaction-level model tracks redirect
//                epochs, in-flight requests and the delivered word stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rv32imf_fetch_ctrl;

    localparam int DEPTH   = 2;
    localparam int MAX_OUT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_i;
    logic        branch_i;
    logic [31:0] branch_addr_i;
    logic        fetch_ready_i;
    logic        fetch_valid_o;
    logic [31:0] fetch_rdata_o;
    logic        fetch_err_o;
    logic        instr_req_o;
    logic [31:0] instr_addr_o;
    logic        instr_gnt_i;
    logic        instr_rvalid_i;
    logic [31:0] instr_rdata_i;
    logic        instr_err_i;
    logic        busy_o;

    always #5 clk = ~clk;

    rv32imf_fetch_ctrl #(
        .DEPTH           (DEPTH),
        .MAX_OUTSTANDING (MAX_OUT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_i          (req_i),
        .branch_i       (branch_i),
        .branch_addr_i  (branch_addr_i),
        .fetch_ready_i  (fetch_ready_i),
        .fetch_valid_o  (fetch_valid_o),
        .fetch_rdata_o  (fetch_rdata_o),
        .fetch_err_o    (fetch_err_o),
        .instr_req_o    (instr_req_o),
        .instr_addr_o   (instr_addr_o),
        .instr_gnt_i    (instr_gnt_i),
        .instr_rvalid_i (instr_rvalid_i),
        .instr_rdata_i  (instr_rdata_i),
        .instr_err_i    (instr_err_i),
        .busy_o         (busy_o)
    );

    // A granted request remembers the redirect epoch in which it was first raised.
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] ep;
    } inf_t;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } ent_t;

    inf_t        q_inf[$];
    ent_t        q_fifo[$];
    logic        m_booted;
    logic        m_pend;
    logic [31:0] m_nxt;
    logic [31:0] m_pend_addr;
    logic [31:0] m_pend_ep;
    logic [31:0] m_ep;
    int          n_checks = 0;
    int          n_errors = 0;

    function automatic logic [31:0] mw(input logic [31:0] a);
        return a ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; req_i = 1'b0; branch_i = 1'b0; branch_addr_i = '0;
        fetch_ready_i = 1'b0; instr_gnt_i = 1'b0; instr_rvalid_i = 1'b0;
        instr_rdata_i = '0; instr_err_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        q_inf.delete(); q_fifo.delete();
        m_booted = 1'b0; m_pend = 1'b0; m_nxt = '0; m_ep = '0;
        m_pend_addr = '0; m_pend_ep = '0;
        #1;
        chk("rst_fetch_valid", fetch_valid_o, 0);
        chk("rst_fetch_rdata", fetch_rdata_o, 0);
        chk("rst_fetch_err",   fetch_err_o,   0);
        chk("rst_instr_req",   instr_req_o,   0);
        chk("rst_instr_addr",  instr_addr_o,  0);
        chk("rst_busy",        busy_o,        0);
    endtask

    task automatic step(input logic req, input logic br, input logic [31:0] baddr,
                        input logic rdy, input logic gnt, input logic rv, input logic erv);
        logic        rv_eff;
        logic        exp_req;
        logic [31:0] req_addr;
        logic [31:0] req_ep;
        inf_t        resp;
        resp   = '0;
        rv_eff = rv && (q_inf.size() != 0);
        req_i = req; branch_i = br; branch_addr_i = baddr; fetch_ready_i = rdy;
        instr_gnt_i = gnt; instr_rvalid_i = rv_eff;
        instr_rdata_i = rv_eff ? mw(q_inf[0].addr) : $urandom();
        instr_err_i   = rv_eff && (erv || q_inf[0].addr == 32'hFFFF_FFFC);
        #2;
        chk("fetch_valid", fetch_valid_o, (q_fifo.size() != 0));
        if (q_fifo.size() != 0) begin
            chk("fetch_rdata", fetch_rdata_o, q_fifo[0].data);
            chk("fetch_err",   fetch_err_o,   q_fifo[0].err);
        end
        exp_req  = m_pend || (req && m_booted && q_inf.size() < MAX_OUT
                              && (q_inf.size() + q_fifo.size()) < DEPTH);
        req_addr = m_pend ? m_pend_addr : m_nxt;
        req_ep   = m_pend ? m_pend_ep   : m_ep;
        chk("instr_req", instr_req_o, exp_req);
        if (exp_req) chk("instr_addr", instr_addr_o, req_addr);
        chk("busy", busy_o, exp_req || (q_inf.size() != 0));
        // Model the effect of the coming edge.
        if (rv_eff) resp = q_inf.pop_front();
        if (exp_req && gnt) begin
            q_inf.push_back('{addr: req_addr, ep: req_ep});
            if (req_ep == m_ep) m_nxt = req_addr + 32'd4;
        end
        m_pend      = exp_req && !gnt;
        m_pend_addr = req_addr;
        m_pend_ep   = req_ep;
        if (q_fifo.size() != 0 && rdy && !br) void'(q_fifo.pop_front());
        if (br) begin
            m_ep     = m_ep + 32'd1;
            m_booted = 1'b1;
            m_nxt    = {baddr[31:2], 2'b00};
            q_fifo.delete();
        end
        if (rv_eff && resp.ep == m_ep) q_fifo.push_back('{data: mw(resp.addr), err: instr_err_i});
        @(posedge clk); #1;
    endtask

    task automatic rand_steps(input int n);
        for (int i = 0; i < n; i++) begin
            step($urandom_range(0, 9) != 0, $urandom_range(0, 19) == 0, $urandom(),
                 $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6,
                 $urandom_range(0, 9) < 6, $urandom_range(0, 9) == 0);
        end
    endtask

    initial begin
        do_reset();
        // No request before the boot redirect even with req_i high.
        step(1, 0, 32'h0, 1, 1, 0, 0);
        // Boot redirect to an unaligned target, then streaming fetch.
        step(1, 1, 32'h0000_1002, 1, 0, 0, 0);
        chk("boot_addr", instr_addr_o, 32'h0000_1000);
        for (int i = 0; i < 6; i++) step(1, 0, 32'h0, 1, 1, 1, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 32'h0, 1, 0, 1, 0);
        // Held request across a redirect to 0x2000.
        step(1, 0, 32'h0, 1, 0, 0, 0);
        step(1, 0, 32'h0, 1, 0, 0, 0);
        step(1, 1, 32'h0000_2000, 1, 0, 0, 0);
        step(0, 0, 32'h0, 1, 0, 0, 0);
        step(0, 0, 32'h0, 1, 0, 0, 0);
        step(1, 0, 32'h0, 1, 1, 0, 0);
        chk("post_hold_addr", instr_addr_o, 32'h0000_2000);
        for (int i = 0; i < 5; i++) step(1, 0, 32'h0, 1, 1, 1, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 32'h0, 1, 0, 1, 0);
        // Two outstanding, then redirect to 0x3000.
        step(1, 0, 32'h0, 1, 1, 0, 0);
        step(1, 0, 32'h0, 1, 1, 0, 0);
        step(1, 1, 32'h0000_3000, 1, 0, 0, 0);
        for (int i = 0; i < 6; i++) step(1, 0, 32'h0, 1, 1, 1, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 32'h0, 1, 0, 1, 0);
        // Consumer stalled: FIFO fills and requests stop.
        for (int i = 0; i < 6; i++) step(1, 0, 32'h0, 0, 1, 1, 0);
        chk("stall_valid", fetch_valid_o, 1);
        chk("stall_no_req", instr_req_o, 0);
        for (int i = 0; i < 6; i++) step(1, 0, 32'h0, 1, 1, 1, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 32'h0, 1, 0, 1, 0);
        // Address wrap with a bus error on the last word.
        step(1, 1, 32'hFFFF_FFF8, 1, 0, 0, 0);
        for (int i = 0; i < 6; i++) step(1, 0, 32'h0, 1, 1, 1, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 32'h0, 1, 0, 1, 0);
        // Randomized traffic, with a reset in the middle of activity.
        rand_steps(2000);
        do_reset();
        rand_steps(1500);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
